ir_key_event: RTL and testbench
===============================

Name: ir_key_event

Overview:
- Sits directly downstream of the IR receive stage and consumes its 32-bit NEC code word and one-cycle new-code strobe.
- Validates each code's complement bytes and optional device address.
- Tracks key hold/release with a timeout and turns raw codes into PRESS / REPEAT / RELEASE events.
- Buffers events in a 4-entry FIFO with a valid/ready handshake for the game/UI logic.

Parameters:
- DEVICE_ADDR, 8'h00, NEC address accepted when CHECK_ADDR=1.
- CHECK_ADDR, 1, 1 = reject codes whose address byte is not DEVICE_ADDR; 0 = accept any address.
- RELEASE_CYCLES, 12_000_000, cycles without a valid code after which a held key counts as released (120 ms at 100 MHz).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; synchronous, active-high
- code_in  input  32  NEC word: [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd
- new_code_in  input  1  one-cycle strobe; code_in is valid in this cycle
- evt_valid_out  output  1  FIFO head holds an event
- evt_ready_in  input  1  consumer accepts the head event when evt_valid_out=1
- evt_type_out  output  2  0=PRESS, 1=REPEAT, 2=RELEASE (3 never produced)
- evt_cmd_out  output  8  command byte of the head event
- held_out  output  1  a key is currently held
- held_cmd_out  output  8  command of the held key (last value kept after release)
- reject_count_out  output  8  rejected-code count, saturates at 255
- overflow_out  output  1  sticky; set when an event is dropped because the FIFO is full

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM in IDLE; timer 0. A reset mid-operation discards queued events and any held key without emitting RELEASE.
- A code is valid when all of the following hold:
  - code_in[23:16] == ~code_in[31:24]
  - code_in[7:0] == ~code_in[15:8]
  - code_in[31:24] == DEVICE_ADDR, or CHECK_ADDR=0
- A code that fails any check, with new_code_in=1, increments reject_count_out (saturating) and causes no state change or event.
- Only new_code_in=1 cycles are evaluated; code_in is ignored otherwise.
- FSM states: IDLE, HELD.
  - IDLE + valid code: push PRESS(cmd), held_cmd_out<=cmd, timer<=0, go to HELD.
  - HELD + valid code, cmd == held_cmd_out: push REPEAT(cmd), timer<=0.
  - HELD + valid code, cmd != held_cmd_out: push PRESS(new cmd), held_cmd_out<=new cmd, timer<=0. No separate RELEASE is emitted; the change is an implied release.
  - HELD, no valid code, timer == RELEASE_CYCLES-1: push RELEASE(held_cmd_out), go to IDLE.
  - HELD otherwise: timer increments.
- Simultaneous valid code and timer expiry in the same cycle: the code wins and the timer restarts. A rejected code does not restart the timer.
- held_out is 1 exactly while the FSM is in HELD. Registered outputs change the cycle after the causing event.
- Event latency: an event pushed in cycle N is visible at the FIFO head in cycle N+1 if the FIFO was empty.
- FIFO: depth 4, 10-bit entries {type, cmd}, first-in first-out.
  - A pop occurs when evt_valid_out && evt_ready_in.
  - evt_type_out / evt_cmd_out show the head entry and are held stable while evt_valid_out=1 and evt_ready_in=0.
  - Push when full with no pop that cycle: the event is dropped, overflow_out<=1, FSM and held state still update.
  - Push and pop in the same cycle when full: both succeed and occupancy stays 4.
  - Pop when empty: no effect.
  - Pointers wrap modulo 4; occupancy is a 3-bit count, 0..4.
- overflow_out is cleared only by rst_in.

Test Plan:
- RELEASE_CYCLES=100, ready tied 1; strobe code 32'h00FF_16E9 once, then wait 120 cycles. Required:
  - PRESS/0x16 event appears 1 cycle after the strobe.
  - held_out=1.
  - RELEASE/0x16 is emitted at 100 idle cycles after the strobe, then held_out=0.
- Strobe 32'h00FF_16E9 three times, 50 cycles apart. Required: PRESS, REPEAT, REPEAT (all 0x16), then a single RELEASE 100 cycles after the last strobe.
- Strobe 32'h00FF_16E9, then 32'h00FF_0CF3 20 cycles later. Required: PRESS 0x16, then PRESS 0x0C; held_cmd_out=0x0C; no RELEASE between them.
- Reject checks: strobe 32'h00FF_16E8 (bad cmd complement) and 32'h01FE_16E9 with CHECK_ADDR=1, DEVICE_ADDR=0. Required: no events, reject_count_out=2. With CHECK_ADDR=0 the second code yields PRESS 0x16.
- evt_ready_in=0; send 5 valid strobes. Required:
  - The FIFO holds 4 events and the 5th is dropped.
  - overflow_out=1.
  - Raising ready drains exactly 4 events in order.
- Reset while HELD with 2 events queued. Required: next cycle evt_valid_out=0, held_out=0, counters 0; no RELEASE emitted afterwards.

Source files
------------

// File: rtl/ir_key_event.sv
// ir_key_event: validates NEC codes, tracks key hold/release and queues
// PRESS/REPEAT/RELEASE events in a 4-entry FIFO with valid/ready output.
module ir_key_event #(
    parameter logic [7:0] DEVICE_ADDR    = 8'h00,
    parameter bit         CHECK_ADDR     = 1'b1,
    parameter int         RELEASE_CYCLES = 12_000_000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] code_in,
    input  logic        new_code_in,
    output logic        evt_valid_out,
    input  logic        evt_ready_in,
    output logic [1:0]  evt_type_out,
    output logic [7:0]  evt_cmd_out,
    output logic        held_out,
    output logic [7:0]  held_cmd_out,
    output logic [7:0]  reject_count_out,
    output logic        overflow_out
);
    localparam int TW = $clog2(RELEASE_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(RELEASE_CYCLES - 1);
    typedef enum logic {IDLE, HELD} state_t;
    state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0] held_d;
    logic [7:0] cmd;
    logic well_formed, valid, reject;
    logic push_req, push, pop;
    logic [1:0] push_type;
    logic [7:0] push_cmd;
    logic [9:0] mem [4];
    logic [1:0] wp, rp;
    logic [2:0] cnt;

    assign cmd = code_in[15:8];
    assign well_formed = code_in[23:16] == ~code_in[31:24] && code_in[7:0] == ~code_in[15:8]
                         && (!CHECK_ADDR || code_in[31:24] == DEVICE_ADDR);
    assign valid  = new_code_in && well_formed;
    assign reject = new_code_in && !well_formed;

    // A valid code always wins over timer expiry and restarts the hold timer.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        held_d    = held_cmd_out;
        push_req  = 1'b0;
        push_type = 2'd0;
        push_cmd  = cmd;
        if (valid) begin
            state_d   = HELD;
            timer_d   = '0;
            held_d    = cmd;
            push_req  = 1'b1;
            push_type = (state_q == HELD && cmd == held_cmd_out) ? 2'd1 : 2'd0;
        end else if (state_q == HELD) begin
            if (timer_q == LAST) begin
                state_d   = IDLE;
                push_req  = 1'b1;
                push_type = 2'd2;
                push_cmd  = held_cmd_out;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    assign evt_valid_out = cnt != 3'd0;
    assign pop  = evt_valid_out && evt_ready_in;
    assign push = push_req && (cnt != 3'd4 || pop);
    assign {evt_type_out, evt_cmd_out} = mem[rp];
    assign held_out = state_q == HELD;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q          <= IDLE;
            timer_q          <= '0;
            held_cmd_out     <= 8'd0;
            reject_count_out <= 8'd0;
            overflow_out     <= 1'b0;
            wp               <= 2'd0;
            rp               <= 2'd0;
            cnt              <= 3'd0;
            for (int i = 0; i < 4; i++) mem[i] <= 10'd0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            held_cmd_out <= held_d;
            if (reject && reject_count_out != 8'hFF) reject_count_out <= reject_count_out + 8'd1;
            if (push_req && !push) overflow_out <= 1'b1;
            if (push) begin
                mem[wp] <= {push_type, push_cmd};
                wp      <= wp + 2'd1;
            end
            if (pop) rp <= rp + 2'd1;
            cnt <= cnt + {2'b0, push} - {2'b0, pop};
        end
    end
endmodule

// File: tb/tb_ir_key_event.sv
// tb_ir_key_event: scoreboard bench with a per-instance behavioural model;
// instance 0 checks the address, instance 1 accepts any address.
module tb_ir_key_event;
    localparam int RC = 100;
    logic clk = 1'b0, rst = 1'b1, strobe = 1'b0, ready = 1'b1, mon_en = 1'b0;
    logic [31:0] code = 32'd0;
    logic v0, h0, ov0, v1, h1, ov1;
    logic [1:0] t0, t1;
    logic [7:0] c0, hc0, rc0, c1, hc1, rc1;

    bit m_held[2], m_ovf[2];
    logic [7:0] m_cmd[2];
    int m_idle[2], m_rej[2], m_occ[2];
    logic [9:0] q0[$], q1[$], log0[$], log1[$];
    int n_cmp = 0, n_err = 0;

    ir_key_event #(.DEVICE_ADDR(8'h00), .CHECK_ADDR(1'b1), .RELEASE_CYCLES(RC)) u_dut0 (
        .clk_in(clk), .rst_in(rst), .code_in(code), .new_code_in(strobe),
        .evt_valid_out(v0), .evt_ready_in(ready), .evt_type_out(t0), .evt_cmd_out(c0),
        .held_out(h0), .held_cmd_out(hc0), .reject_count_out(rc0), .overflow_out(ov0));
    ir_key_event #(.DEVICE_ADDR(8'h00), .CHECK_ADDR(1'b0), .RELEASE_CYCLES(RC)) u_dut1 (
        .clk_in(clk), .rst_in(rst), .code_in(code), .new_code_in(strobe),
        .evt_valid_out(v1), .evt_ready_in(ready), .evt_type_out(t1), .evt_cmd_out(c1),
        .held_out(h1), .held_cmd_out(hc1), .reject_count_out(rc1), .overflow_out(ov1));

    always #5 clk = ~clk;

    function automatic logic [31:0] nec(logic [7:0] a, logic [7:0] c);
        return {a, ~a, c, ~c};
    endfunction

    function automatic bit code_ok(logic [31:0] c, int i);
        return c[23:16] == ~c[31:24] && c[7:0] == ~c[15:8] && (i == 1 || c[31:24] == 8'h00);
    endfunction

    function automatic void cmp(string name, int i, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h want %0h at %0t", name, i, act, exp, $time);
        end
    endfunction

    // Reference: a key is held until RC consecutive cycles pass without a valid code.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit ev, pop;
            logic [9:0] e;
            ev = 1'b0;
            e = '0;
            if (rst) begin
                m_held[i] = 0; m_cmd[i] = 0; m_idle[i] = 0; m_rej[i] = 0; m_occ[i] = 0; m_ovf[i] = 0;
                if (i == 0) q0.delete(); else q1.delete();
            end else begin
                if (strobe && code_ok(code, i)) begin
                    e = {(m_held[i] && code[15:8] == m_cmd[i]) ? 2'd1 : 2'd0, code[15:8]};
                    ev = 1'b1;
                    m_held[i] = 1;
                    m_cmd[i] = code[15:8];
                    m_idle[i] = 0;
                end else begin
                    if (strobe) m_rej[i] = (m_rej[i] < 255) ? m_rej[i] + 1 : 255;
                    if (m_held[i]) begin
                        m_idle[i]++;
                        if (m_idle[i] == RC) begin
                            ev = 1'b1;
                            e = {2'd2, m_cmd[i]};
                            m_held[i] = 0;
                        end
                    end
                end
                pop = m_occ[i] > 0 && ready;
                if (ev) begin
                    if (m_occ[i] < 4 || pop) begin
                        if (i == 0) q0.push_back(e); else q1.push_back(e);
                        m_occ[i]++;
                    end else m_ovf[i] = 1;
                end
                if (pop) m_occ[i]--;
            end
        end
    endtask

    task automatic check(int i, logic v, logic [1:0] t, logic [7:0] c, logic h,
                         logic [7:0] hc, logic [7:0] rc, logic ov);
        logic [9:0] e;
        cmp("evt_valid", i, v, m_occ[i] > 0);
        cmp("held", i, h, m_held[i]);
        cmp("held_cmd", i, hc, m_cmd[i]);
        cmp("reject_count", i, rc, m_rej[i]);
        cmp("overflow", i, ov, m_ovf[i]);
        if (v === 1'b1 && ready) begin
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_event[%0d]: got %0h want none", i, {t, c});
            end else begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                cmp("event", i, {t, c}, e);
            end
            if (i == 0) log0.push_back({t, c}); else log1.push_back({t, c});
        end
    endtask

    always @(negedge clk) if (mon_en) begin
        check(0, v0, t0, c0, h0, hc0, rc0, ov0);
        check(1, v1, t1, c1, h1, hc1, rc1, ov1);
    end

    task automatic tick(logic [31:0] c, logic s);
        code = c;
        strobe = s;
        @(negedge clk);
        #1 model_step();
        @(posedge clk);
        #1 strobe = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) tick($urandom, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(32'd0, 1'b0);
        rst = 1'b0;
        log0.delete();
        log1.delete();
    endtask

    task automatic chk_log(string name, int i, int n, logic [9:0] ex[4]);
        int sz;
        sz = (i == 0) ? log0.size() : log1.size();
        cmp({name, "_count"}, i, sz, n);
        for (int k = 0; k < n && k < sz; k++)
            cmp(name, i, (i == 0) ? log0[k] : log1[k], ex[k]);
    endtask

    initial begin
        logic [9:0] ex[4];
        tick(32'd0, 1'b0);
        rst = 1'b0;
        mon_en = 1'b1;
        cmp("reset_valid", 0, v0, 1'b0);
        cmp("reset_regs", 0, {h0, hc0, rc0, ov0}, 18'd0);

        // single press, then release after RC idle cycles
        do_reset();
        tick(32'h00FF_16E9, 1'b1);
        cmp("press_latency", 0, {v0, t0, c0}, {1'b1, 2'd0, 8'h16});
        cmp("press_held", 0, h0, 1'b1);
        idle(RC - 1);
        cmp("pre_release", 0, {v0, h0}, 2'b01);
        tick(32'd0, 1'b0);
        cmp("release_evt", 0, {v0, t0, c0}, {1'b1, 2'd2, 8'h16});
        cmp("release_held", 0, h0, 1'b0);
        idle(5);

        // repeats
        do_reset();
        tick(32'h00FF_16E9, 1'b1); idle(49);
        tick(32'h00FF_16E9, 1'b1); idle(49);
        tick(32'h00FF_16E9, 1'b1); idle(RC + 5);
        ex = '{{2'd0, 8'h16}, {2'd1, 8'h16}, {2'd1, 8'h16}, {2'd2, 8'h16}};
        chk_log("repeat_seq", 0, 4, ex);

        // key change is an implied release
        do_reset();
        tick(32'h00FF_16E9, 1'b1); idle(19);
        tick(32'h00FF_0CF3, 1'b1); idle(5);
        ex = '{{2'd0, 8'h16}, {2'd0, 8'h0C}, 10'd0, 10'd0};
        chk_log("key_change", 0, 2, ex);
        cmp("key_change_held_cmd", 0, hc0, 8'h0C);

        // rejects; instance 1 ignores the address
        do_reset();
        tick(32'h00FF_16E8, 1'b1); idle(2);
        tick(32'h01FE_16E9, 1'b1); idle(3);
        ex = '{{2'd0, 8'h16}, 10'd0, 10'd0, 10'd0};
        chk_log("reject_events", 0, 0, ex);
        cmp("reject_count", 0, rc0, 8'd2);
        chk_log("any_addr", 1, 1, ex);
        cmp("reject_count_any_addr", 1, rc1, 8'd1);

        // overflow
        do_reset();
        ready = 1'b0;
        for (int k = 1; k <= 5; k++) tick(nec(8'h00, 8'(k)), 1'b1);
        idle(3);
        cmp("full_valid", 0, v0, 1'b1);
        cmp("overflow_set", 0, ov0, 1'b1);
        ready = 1'b1;
        idle(6);
        ex = '{{2'd0, 8'h01}, {2'd0, 8'h02}, {2'd0, 8'h03}, {2'd0, 8'h04}};
        chk_log("drain", 0, 4, ex);
        cmp("overflow_sticky", 0, ov0, 1'b1);

        // reset while held with events queued
        do_reset();
        ready = 1'b0;
        tick(32'h00FF_16E9, 1'b1); idle(1);
        tick(32'h00FF_0CF3, 1'b1); idle(1);
        do_reset();
        cmp("rst_mid_valid", 0, v0, 1'b0);
        cmp("rst_mid_regs", 0, {h0, hc0, rc0, ov0}, 18'd0);
        ready = 1'b1;
        idle(RC + 20);
        ex = '{10'd0, 10'd0, 10'd0, 10'd0};
        chk_log("no_release_after_rst", 0, 0, ex);

        // randomized traffic with bursty strobes
        for (int n = 0; n < 4000; n++) begin
            int sel;
            logic [7:0] cm;
            logic [31:0] c;
            ready = ($urandom_range(3) != 0);
            rst = ($urandom_range(999) == 0);
            sel = $urandom_range(7);
            cm = (sel < 4) ? 8'h16 : (sel < 6) ? 8'h0C : 8'h33;
            case ($urandom_range(5))
                0: c = nec(8'h01, cm);
                1: c = nec(8'h00, cm) ^ 32'h0000_0001;
                2: c = $urandom;
                default: c = nec(8'h00, cm);
            endcase
            tick(c, ((n / 300) % 2 == 0) ? ($urandom_range(7) == 0) : ($urandom_range(199) == 0));
            rst = 1'b0;
        end
        ready = 1'b1;
        idle(RC + 10);
        cmp("final_drain", 0, q0.size(), 0);
        cmp("final_drain", 1, q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
